dual_source_write_arbiter: RTL and testbench
============================================

# dual_source_write_arbiter

Round-robin arbiter that shares one registered data path between two burst-oriented writers, e.g. the animation generator and the host bridge both feeding the frame-buffer write port of the LED cube. It grants one requester at a time, holds the grant for a whole burst, and forwards the granted source's beats through a registered two-way select. An optional watchdog caps burst length so a stuck writer cannot starve the other.

## Interface

Parameters:
- WIDTH, 16, data beat width in bits
- MAX_BURST, 64, beat limit per grant when the watchdog is compiled in; legal range 2..1024

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  source requests access; must stay high for the whole burst
- valid0 / valid1  in  1  source presents a beat this cycle
- last0 / last1  in  1  qualifies the final beat of a burst; only meaningful with validN
- data0 / data1  in  WIDTH  source beat data
- gnt0 / gnt1  out  1  registered grant, one-hot or both low
- out_valid  out  1  registered forwarded-beat strobe
- out_src  out  1  source index of the beat on out_data
- out_data  out  WIDTH  registered forwarded beat
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release

## Operation

- States: IDLE, GRANT0, GRANT1. last_served is a 1-bit pointer.
- IDLE:
  - req0 & req1: grant the source not equal to last_served.
  - A single request: grant that source.
  - No request: stay in IDLE.
- Entering GRANTn sets last_served = n.
- GRANTn:
  - A beat is accepted on any edge where validn is high.
  - The other source's valid, last and data are ignored.
- GRANTn exits to IDLE on whichever comes first:
  - an accepted beat with lastn;
  - reqn low (abandoned burst; no beat accepted that cycle even if validn);
  - watchdog expiry.
- The arbiter never switches directly GRANT0↔GRANT1. IDLE always lasts exactly one cycle between grants.
- Forwarding:
  - out_valid <= accepted beat.
  - out_data <= accepted data, otherwise it holds its last value.
  - out_src <= granted index, otherwise it holds.
- Beat counter:
  - Width $clog2(MAX_BURST)+1.
  - Cleared on entry to GRANTn, incremented per accepted beat.

## Timing

- Reset values (async assert, sync release): state IDLE, last_served=1, gnt0=gnt1=0, out_valid=0, out_src=0, out_data=0, beat count 0, timeout_err=0.
- reqn sampled high in IDLE at edge E: gntn high from E+1.
- Beat accepted at edge E: out_valid/out_data/out_src visible E+1. Fixed latency of 1 cycle.
- The last beat accepted at edge E:
  - gntn low from E+1;
  - next grant asserts E+2 at the earliest.
- validn sampled on the same edge that the grant is first seen high is accepted. A source may therefore stream from the first cycle it sees gntn.
- reqn dropped mid-burst: gntn low the following cycle. No flush and no error flag.
- reset_n asserted mid-burst: all outputs clear immediately. The partial burst is discarded and the arbiter restarts with source 0 preferred.
- Simultaneous req0 and req1 from reset: source 0 wins. A sustained double request then alternates bursts 0,1,0,1.

## Configuration

- ARBITER_TIMEOUT_EN defined:
  - When the MAX_BURST-th beat is accepted without lastn, the arbiter returns to IDLE on the next edge.
  - That beat is still forwarded.
  - timeout_err pulses high for one cycle, aligned with the gnt fall.
- ARBITER_TIMEOUT_EN undefined:
  - Bursts are unbounded.
  - The counter and compare logic are removed.
  - timeout_err is tied 0.

## Test plan

- Reset then req0 = req1 = 1, each sending 3-beat bursts 0xA000..A002 and 0xB000..B002 -> gnt0 first; out_data A000,A001,A002 with out_src=0; one IDLE cycle; then B000..B002 with out_src=1; then source 0 again.
- Single req1 only, 1-beat burst (valid1 & last1 on the first granted cycle) -> gnt1 high exactly 1 cycle; out_valid 1 cycle later with out_data=data1.
- Source 0 granted with valid0 gaps (beats on cycles 1, 3, 4; last on 4) -> exactly 3 out_valid pulses, no beats from source 1 despite valid1 toggling.
- req0 dropped after 2 of 5 beats while req1 pending -> gnt0 falls next cycle; gnt1 asserts 2 cycles after the drop; timeout_err stays 0.
- ARBITER_TIMEOUT_EN, MAX_BURST=4, source 0 streams 10 beats without last0 and req1 pending -> 4 beats forwarded; timeout_err pulses once; gnt1 granted next. Without the macro, all 10 beats are forwarded.
- reset_n pulsed low during beat 2 of a burst -> gnt and out_valid drop asynchronously; after release, state is IDLE and source 0 wins the next tie.

Source files
------------

// File: rtl/dual_source_write_arbiter.sv
// dual_source_write_arbiter
// Round-robin arbiter sharing one registered write path between two burst
// writers. A grant is held for a whole burst. The granted source's beats are
// forwarded through a registered two-way select with one cycle of latency.
// Optional burst watchdog: define ARBITER_TIMEOUT_EN to cap a burst at
// MAX_BURST beats and pulse timeout_err when the cap forces a release.
module dual_source_write_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             last0,
  input  logic             last1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  output logic             out_src,
  output logic [WIDTH-1:0] out_data,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  if (MAX_BURST < 2 || MAX_BURST > 1024) begin : g_bad_max_burst
    $error("dual_source_write_arbiter: MAX_BURST must be within 2..1024");
  end

  state_t           state;
  logic             last_served;

  logic             accept0;
  logic             accept1;
  logic             accept;
  logic             accept_last;
  logic             abandon;
  logic             expire;
  logic             release_grant;
  logic [WIDTH-1:0] accept_data;

`ifdef ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] beat_cnt;
`endif

  // Beat acceptance and grant-release decode for the current state
  always_comb begin
    accept0       = (state == GRANT0) && req0 && valid0;
    accept1       = (state == GRANT1) && req1 && valid1;
    accept        = accept0 || accept1;
    accept_last   = (accept0 && last0) || (accept1 && last1);
    abandon       = ((state == GRANT0) && !req0) || ((state == GRANT1) && !req1);
    accept_data   = accept1 ? data1 : data0;
`ifdef ARBITER_TIMEOUT_EN
    // beat_cnt holds beats already taken, so MAX_BURST-1 means this is the cap beat
    expire        = accept && !accept_last && (beat_cnt == CNT_W'(MAX_BURST - 1));
`else
    expire        = 1'b0;
`endif
    release_grant = accept_last || abandon || expire;
  end

  // Arbitration FSM with registered grants and forwarded beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      out_valid   <= 1'b0;
      out_src     <= 1'b0;
      out_data    <= '0;
`ifdef ARBITER_TIMEOUT_EN
      beat_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_data <= accept_data;
        out_src  <= accept1;
      end
`ifdef ARBITER_TIMEOUT_EN
      timeout_err <= expire;
`endif
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_served)) begin
            state       <= GRANT0;
            gnt0        <= 1'b1;
            last_served <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
            beat_cnt    <= '0;
`endif
          end else if (req1) begin
            state       <= GRANT1;
            gnt1        <= 1'b1;
            last_served <= 1'b1;
`ifdef ARBITER_TIMEOUT_EN
            beat_cnt    <= '0;
`endif
          end
        end
        GRANT0, GRANT1: begin
          if (release_grant) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
          end
`ifdef ARBITER_TIMEOUT_EN
          else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
      endcase
    end
  end

`ifndef ARBITER_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_source_write_arbiter.sv
// Directed testbench for dual_source_write_arbiter.
// Built with MAX_BURST=4; watchdog expectations follow ARBITER_TIMEOUT_EN.
module tb_dual_source_write_arbiter;

`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        req0, req1, valid0, valid1, last0, last1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, out_valid, out_src, timeout_err;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  dual_source_write_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .req1       (req1),
    .valid0     (valid0),
    .valid1     (valid1),
    .last0      (last0),
    .last1      (last1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .out_valid  (out_valid),
    .out_src    (out_src),
    .out_data   (out_data),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int to_pulses;
    int lim;
    logic [4:0] pat;

    reset_n = 1'b0;
    req0 = 0; req1 = 0; valid0 = 0; valid1 = 0; last0 = 0; last1 = 0;
    data0 = '0; data1 = '0;

    // Reset state
    #12;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_timeout", timeout_err, 0);
    #8;
    reset_n = 1'b1;

    // Test 1: tie from reset, 3-beat bursts alternating 0,1,0
    req0 = 1; req1 = 1;
    step();
    check("t1_gnt0_first", gnt0, 1);
    check("t1_gnt1_first", gnt1, 0);
    for (int i = 0; i < 3; i++) begin
      valid0 = 1; data0 = 16'hA000 + 16'(i); last0 = (i == 2);
      step();
      check("t1_a_valid", out_valid, 1);
      check("t1_a_data", out_data, 16'hA000 + 16'(i));
      check("t1_a_src", out_src, 0);
      check("t1_a_gnt0", gnt0, (i < 2) ? 1 : 0);
    end
    valid0 = 0; last0 = 0;
    step();
    check("t1_gnt1", gnt1, 1);
    check("t1_gnt0_off", gnt0, 0);
    check("t1_idle_valid", out_valid, 0);
    check("t1_hold_data", out_data, 16'hA002);
    for (int i = 0; i < 3; i++) begin
      valid1 = 1; data1 = 16'hB000 + 16'(i); last1 = (i == 2);
      step();
      check("t1_b_valid", out_valid, 1);
      check("t1_b_data", out_data, 16'hB000 + 16'(i));
      check("t1_b_src", out_src, 1);
      check("t1_b_gnt1", gnt1, (i < 2) ? 1 : 0);
    end
    valid1 = 0; last1 = 0;
    step();
    check("t1_gnt0_again", gnt0, 1);
    check("t1_gnt1_again", gnt1, 0);
    req0 = 0; req1 = 0;
    step();
    check("t1_abandon_gnt0", gnt0, 0);

    // Test 2: single req1, one-beat burst
    req1 = 1;
    step();
    check("t2_gnt1", gnt1, 1);
    valid1 = 1; last1 = 1; data1 = 16'h1234;
    step();
    check("t2_gnt1_fall", gnt1, 0);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 16'h1234);
    check("t2_src", out_src, 1);
    req1 = 0; valid1 = 0; last1 = 0;
    step();
    check("t2_gnt1_stays_low", gnt1, 0);
    check("t2_valid_off", out_valid, 0);

    // Test 3: source 0 with valid gaps, source 1 valid toggling without grant
    req0 = 1;
    step();
    check("t3_gnt0", gnt0, 1);
    pat = 5'b11010;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      valid0 = pat[c]; data0 = 16'hC000 + 16'(c); last0 = (c == 4);
      valid1 = c[0]; data1 = 16'hDEAD; last1 = 1;
      step();
      check("t3_valid", out_valid, pat[c]);
      if (out_valid) pulses++;
      if (pat[c]) begin
        check("t3_data", out_data, 16'hC000 + 16'(c));
        check("t3_src", out_src, 0);
      end
    end
    check("t3_gnt0_fall", gnt0, 0);
    req0 = 0; valid0 = 0; last0 = 0; valid1 = 0; last1 = 0;
    step();
    if (out_valid) pulses++;
    check("t3_pulses", pulses, 3);
    check("t3_no_gnt1", gnt1, 0);

    // Test 4: req0 dropped after 2 of 5 beats while req1 pending
    req0 = 1;
    step();
    check("t4_gnt0", gnt0, 1);
    req1 = 1;
    for (int i = 0; i < 2; i++) begin
      valid0 = 1; data0 = 16'hD000 + 16'(i); last0 = 0;
      step();
      check("t4_data", out_data, 16'hD000 + 16'(i));
      check("t4_gnt0_hold", gnt0, 1);
    end
    req0 = 0; data0 = 16'hD002;
    step();
    check("t4_gnt0_drop", gnt0, 0);
    check("t4_gnt1_not_yet", gnt1, 0);
    check("t4_no_beat", out_valid, 0);
    check("t4_hold_data", out_data, 16'hD001);
    check("t4_timeout", timeout_err, 0);
    valid0 = 0;
    step();
    check("t4_gnt1", gnt1, 1);
    check("t4_timeout2", timeout_err, 0);
    valid1 = 1; last1 = 1; data1 = 16'hE000;
    step();
    check("t4_e_data", out_data, 16'hE000);
    check("t4_e_src", out_src, 1);
    check("t4_gnt1_fall", gnt1, 0);
    req1 = 0; valid1 = 0; last1 = 0;
    step();

    // Test 5: source 0 streams 10 beats without last0, req1 pending
    req0 = 1; req1 = 1;
    step();
    check("t5_gnt0", gnt0, 1);
    lim = TO_EN ? 4 : 10;
    pulses = 0;
    to_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      valid0 = 1; data0 = 16'hF000 + 16'(i); last0 = 0;
      step();
      if (out_valid) pulses++;
      if (timeout_err) to_pulses++;
      check("t5_valid", out_valid, (i < lim) ? 1 : 0);
      check("t5_data", out_data, 16'hF000 + 16'((i < lim) ? i : lim - 1));
      check("t5_timeout", timeout_err, (TO_EN && i == 3) ? 1 : 0);
      check("t5_gnt0", gnt0, (!TO_EN || i < 3) ? 1 : 0);
      check("t5_gnt1", gnt1, (TO_EN && i >= 4) ? 1 : 0);
    end
    check("t5_pulses", pulses, lim);
    check("t5_to_pulses", to_pulses, TO_EN ? 1 : 0);
    req0 = 0; req1 = 0; valid0 = 0;
    step();
    check("t5_clear_gnt0", gnt0, 0);
    check("t5_clear_gnt1", gnt1, 0);

    // Test 6: reset pulsed during beat 2
    req0 = 1;
    step();
    check("t6_gnt0", gnt0, 1);
    valid0 = 1; data0 = 16'h7000;
    step();
    check("t6_beat1", out_valid, 1);
    check("t6_beat1_data", out_data, 16'h7000);
    data0 = 16'h7001;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_gnt0", gnt0, 0);
    check("t6_async_valid", out_valid, 0);
    check("t6_async_data", out_data, 0);
    valid0 = 0; req1 = 1;
    step();
    check("t6_held_gnt0", gnt0, 0);
    #4;
    reset_n = 1'b1;
    step();
    check("t6_tie_gnt0", gnt0, 1);
    check("t6_tie_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
